// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer for a single-port,
// word-addressed data memory. Loads and whole-word stores take one memory
// cycle. Sub-word stores are turned into a read-modify-write because the
// memory only accepts whole-word writes.
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking. By
// default port 0 wins ties (fixed priority).
// Handshake: a requester holds pN_req and its fields until pN_gnt pulses.
// The fields are latched on that edge. pN_done pulses once when the access
// completes, with pN_rdata valid in that same cycle.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic [3:0]        p0_be,
   output logic              p0_gnt,
   output logic              p0_done,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   input  logic [3:0]        p1_be,
   output logic              p1_gnt,
   output logic              p1_done,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      MERGE  = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [ADDR_W-3:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [3:0]          be_q, be_d;
   logic                owner_q, owner_d;
   logic                last_owner_q, last_owner_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [DATA_W-1:0]   old_q, old_d;
   logic [DATA_W-1:0]   merged;
   logic                win;
   logic                grant;

   // Byte-offset bits never reach the word-addressed memory.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{p0_addr[1:0], p1_addr[1:0]};

   assign dbg_state = state_q;

   // Pick the winning port. Grant only in IDLE and never while reset is held.
   always_comb begin
      win = 1'b0;
      if (p0_req && p1_req) begin
`ifdef DMEM_ARB_RR_EN
         win = ~last_owner_q;
`else
         win = 1'b0;
`endif
      end else begin
         win = ~p0_req;
      end
      grant = (state_q == IDLE) && (p0_req || p1_req) && rst_n;
   end

   // Merge store bytes over the old word captured in ACCESS.
   always_comb begin
      merged = old_q;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : old_q[8*i +: 8];
      end
   end

   // Next state and all outputs. Memory strobes come only from the state register.
   always_comb begin
      state_d        = state_q;
      p0_gnt         = 1'b0;
      p1_gnt         = 1'b0;
      p0_done        = 1'b0;
      p1_done        = 1'b0;
      p0_rdata       = '0;
      p1_rdata       = '0;
      mem_addr       = '0;
      mem_write_data = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant) begin
               p0_gnt  = ~win;
               p1_gnt  = win;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            mem_addr = {addr_q, 2'b00};
            if (!we_q) begin
               mem_read = 1'b1;
               state_d  = RESP;
            end else if (be_q == 4'hF) begin
               mem_write      = 1'b1;
               mem_write_data = wdata_q;
               state_d        = RESP;
            end else if (be_q == 4'h0) begin
               state_d = RESP;
            end else begin
               mem_read = 1'b1;
               state_d  = MERGE;
            end
         end
         MERGE: begin
            mem_addr       = {addr_q, 2'b00};
            mem_write      = 1'b1;
            mem_write_data = merged;
            state_d        = RESP;
         end
         RESP: begin
            p0_done  = ~owner_q;
            p1_done  = owner_q;
            p0_rdata = owner_q ? '0 : rdata_q;
            p1_rdata = owner_q ? rdata_q : '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: latch the winner's fields on grant, capture read data in ACCESS.
   always_comb begin
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      rdata_d      = rdata_q;
      old_d        = old_q;
      if (grant) begin
         owner_d      = win;
         last_owner_d = win;
         if (win) begin
            we_d    = p1_we;
            addr_d  = p1_addr[ADDR_W-1:2];
            wdata_d = p1_wdata;
            be_d    = p1_be;
         end else begin
            we_d    = p0_we;
            addr_d  = p0_addr[ADDR_W-1:2];
            wdata_d = p0_wdata;
            be_d    = p0_be;
         end
      end
      if (state_q == ACCESS) begin
         rdata_d = we_q ? '0 : mem_read_data;
         old_d   = mem_read_data;
      end
   end

   // State and datapath registers. last_owner resets to 1 so port 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         rdata_q      <= '0;
         old_q        <= '0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         rdata_q      <= rdata_d;
         old_q        <= old_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed timing checks plus randomized two-port traffic
// for dmem_arbiter. The reference model keeps a plain word array and applies
// each access at issue time. It pushes the expected response into a per-port
// queue, and a monitor pops that queue on every done pulse.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [3:0]  p0_be, p1_be;
   logic        p0_gnt, p0_done, p1_gnt, p1_done;
   logic [31:0] p0_rdata, p1_rdata;
   logic [31:0] mem_addr, mem_write_data, mem_read_data;
   logic        mem_read, mem_write;
   logic [1:0]  dbg_state;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];

   int n_checks = 0;
   int n_fail   = 0;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_be(p0_be), .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_be(p1_be), .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_read_data(mem_read_data), .dbg_state(dbg_state)
   );

   // Clock and the memory the DUT drives.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign mem_read_data = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[9:2]] <= mem_write_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: apply one access to the word array, return the expected rdata.
   function automatic logic [31:0] model_access(input logic we, input logic [31:0] addr,
                                                input logic [31:0] wd, input logic [3:0] be);
      logic [7:0]  idx;
      logic [31:0] w;
      idx = addr[9:2];
      if (!we) return ref_mem[idx];
      w = ref_mem[idx];
      for (int b = 0; b < 4; b++) begin
         if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      end
      ref_mem[idx] = w;
      return 32'h0;
   endfunction

   task automatic set_port(input int port, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
      if (port == 0) begin
         p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd; p0_be = be;
      end else begin
         p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd; p1_be = be;
      end
   endtask

   function automatic logic gnt_of(input int port);
      return (port == 0) ? p0_gnt : p1_gnt;
   endfunction

   // Driver: raise a request, wait (bounded) for its grant, drop it after the grant edge.
   // Returns at 1 time unit after the grant edge, i.e. in the ACCESS cycle.
   task automatic issue(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input bit expect_done);
      logic [31:0] e;
      int          waited;
      if (expect_done) begin
         e = model_access(we, addr, wd, be);
         if (port == 0) exp_q0.push_back(e);
         else           exp_q1.push_back(e);
      end
      @(negedge clk);
      set_port(port, 1'b1, we, addr, wd, be);
      waited = 0;
      #1;
      while (!gnt_of(port) && waited < 60) begin
         @(negedge clk);
         #1;
         waited++;
      end
      check($sformatf("p%0d_gnt_seen", port), 32'(gnt_of(port)), 32'h1);
      @(posedge clk);
      #1;
      set_port(port, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bus(input string tag, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] wd, input logic [1:0] dn);
      check({tag, "_mem_read"},  32'(mem_read),  32'(rd));
      check({tag, "_mem_write"}, 32'(mem_write), 32'(wr));
      check({tag, "_mem_addr"},  mem_addr,       a);
      check({tag, "_mem_wdata"}, mem_write_data, wd);
      check({tag, "_done"},      32'({p1_done, p0_done}), 32'(dn));
   endtask

   // Scoreboard monitor: pop and compare on every done pulse; idle outputs stay quiet.
   always @(negedge clk) begin
      if (rst_n) begin
         check("mem_rw_exclusive", 32'(mem_read & mem_write), 32'h0);
         check("single_gnt", 32'(p0_gnt & p1_gnt), 32'h0);
         check("single_done", 32'(p0_done & p1_done), 32'h0);
         if (p0_done) begin
            if (exp_q0.size() == 0) check("p0_done_unexpected", 32'h1, 32'h0);
            else check("p0_rdata", p0_rdata, exp_q0.pop_front());
         end else begin
            check("p0_rdata_idle", p0_rdata, 32'h0);
         end
         if (p1_done) begin
            if (exp_q1.size() == 0) check("p1_done_unexpected", 32'h1, 32'h0);
            else check("p1_rdata", p1_rdata, exp_q1.pop_front());
         end else begin
            check("p1_rdata_idle", p1_rdata, 32'h0);
         end
      end
   end

   // Random traffic for one port, confined to its own half of memory.
   task automatic random_port(input int port, input int count);
      logic [31:0] a;
      logic [3:0]  be;
      logic        we;
      for (int k = 0; k < count; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         a  = {22'h0, 1'(port), 7'($urandom_range(0, 127)), 2'($urandom_range(0, 3))};
         we = 1'($urandom_range(0, 1));
         be = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         issue(port, we, a, $urandom, be, 1'b1);
      end
   endtask

   initial begin
      int got [4];
      int exp_order [4];
      int ngr;

      // Hard watchdog in case the whole run wedges.
      fork
         begin
            #400000;
            $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
            $fatal(1, "watchdog");
         end
      join_none

      rst_n = 1'b0;
      set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      for (int i = 0; i < 256; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[1] = 32'hAABBCCDD; ref_mem[1] = 32'hAABBCCDD;
      mem[2] = 32'hDEADBEEF; ref_mem[2] = 32'hDEADBEEF;
      mem[3] = 32'h11223344; ref_mem[3] = 32'h11223344;

      // Reset values, with a request already pending.
      #2;
      p0_req = 1'b1;
      p1_req = 1'b1;
      #1;
      check("rst_p0_gnt", 32'(p0_gnt), 32'h0);
      check("rst_p1_gnt", 32'(p1_gnt), 32'h0);
      check_bus("rst", 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      check("rst_p0_rdata", p0_rdata, 32'h0);
      check("rst_p1_rdata", p1_rdata, 32'h0);
      @(negedge clk);
      p0_req = 1'b0;
      p1_req = 1'b0;
      rst_n  = 1'b1;

      // Port 0 load of word 2.
      issue(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1);
      check_bus("ld_acc", 1'b1, 1'b0, 32'h8, 32'h0, 2'b00);
      step();
      check_bus("ld_resp", 1'b0, 1'b0, 32'h0, 32'h0, 2'b01);
      step();

      // Port 1 full-word store, then read it back.
      issue(1, 1'b1, 32'h10, 32'h12345678, 4'hF, 1'b1);
      check_bus("st_acc", 1'b0, 1'b1, 32'h10, 32'h12345678, 2'b00);
      step();
      check_bus("st_resp", 1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
      step();
      issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
      step();
      step();
      check("st_word", mem[4], 32'h12345678);

      // Partial store of byte 1 into word 1.
      issue(0, 1'b1, 32'h4, 32'h0000EE00, 4'h2, 1'b1);
      check_bus("ps_acc", 1'b1, 1'b0, 32'h4, 32'h0, 2'b00);
      step();
      check_bus("ps_mrg", 1'b0, 1'b1, 32'h4, 32'hAABBEEDD, 2'b00);
      step();
      check_bus("ps_resp", 1'b0, 1'b0, 32'h0, 32'h0, 2'b01);
      step();
      check("ps_word", mem[1], 32'hAABBEEDD);

      // Store with no byte enables: no memory strobe at all.
      issue(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b1);
      check_bus("be0_acc", 1'b0, 1'b0, 32'h20, 32'h0, 2'b00);
      step();
      check_bus("be0_resp", 1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
      step();
      check("be0_word", mem[8], ref_mem[8]);

      // Reset during MERGE: write suppressed, no done, transaction lost.
      issue(0, 1'b1, 32'hC, 32'h000000AA, 4'h1, 1'b0);
      step();
      check("rstm_merge_write", 32'(mem_write), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstm_write_drop", 32'(mem_write), 32'h0);
      check("rstm_addr_drop", mem_addr, 32'h0);
      check("rstm_wdata_drop", mem_write_data, 32'h0);
      check("rstm_done", 32'({p1_done, p0_done}), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("rstm_word", mem[3], 32'h11223344);

      // Both ports request continuously: record the first four grants.
`ifdef DMEM_ARB_RR_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      got = '{2, 2, 2, 2};
      ngr = 0;
      set_port(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      set_port(1, 1'b1, 1'b0, 32'h240, 32'h0, 4'h0);
      for (int c = 0; c < 60 && ngr < 4; c++) begin
         #1;
         if (p0_gnt || p1_gnt) begin
            got[ngr] = p1_gnt ? 1 : 0;
            if (p1_gnt) exp_q1.push_back(model_access(1'b0, 32'h240, 32'h0, 4'h0));
            else        exp_q0.push_back(model_access(1'b0, 32'h40, 32'h0, 4'h0));
            ngr++;
         end
         if (ngr < 4) @(negedge clk);
      end
      @(posedge clk);
      #1;
      set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      for (int k = 0; k < 4; k++) check($sformatf("arb_grant_%0d", k), 32'(got[k]), 32'(exp_order[k]));

      // Randomized concurrent traffic.
      fork
         random_port(0, 30);
         random_port(1, 30);
      join

      // Drain outstanding responses (bounded).
      for (int c = 0; c < 50 && (exp_q0.size() != 0 || exp_q1.size() != 0); c++) @(negedge clk);
      check("drain_q0", 32'(exp_q0.size()), 32'h0);
      check("drain_q1", 32'(exp_q1.size()), 32'h0);
      repeat (2) @(negedge clk);

      for (int i = 0; i < 256; i++) check($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-port, word-addressed data memory (256 × 32-bit, combinational read, write on rising clk edge). Port 0 is the core load/store unit and port 1 is a secondary master (debug/DMA loader). The block serialises their requests with a request/grant handshake and registers read data. It turns sub-word stores into a read-modify-write sequence, because the memory only accepts whole-word writes.

## Interface
- ADDR_W, 32, byte-address width of requester and memory ports
- DATA_W, 32, data width; fixed at 32 because byte enables are 4 bits
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- pN_req  input  1  access request (N = 0, 1); held with its fields until pN_gnt
- pN_we  input  1  1 = store, 0 = load
- pN_addr  input  ADDR_W  byte address; bits [1:0] ignored
- pN_wdata  input  DATA_W  store data, byte lanes aligned to the word
- pN_be  input  4  store byte enables; ignored for loads
- pN_gnt  output  1  one-cycle pulse: request accepted and fields latched
- pN_done  output  1  one-cycle pulse: access complete
- pN_rdata  output  DATA_W  load data, valid while pN_done=1
- mem_addr  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_write_data  output  DATA_W  word to write
- mem_read  output  1  memory read enable
- mem_write  output  1  memory write enable
- mem_read_data  input  DATA_W  combinational memory read data

## Operation
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE, any req high:
  - Pick a winner and assert its pN_gnt combinationally in the same cycle.
  - Latch we/addr/wdata/be and the owner.
  - Go to ACCESS.
- IDLE, no req: stay in IDLE.
- ACCESS:
  - Load: mem_read=1; rdata_q <= mem_read_data; go to RESP.
  - Store with be=4'hF: mem_write=1, mem_write_data=wdata; go to RESP.
  - Store with be in 4'h1..4'hE: mem_read=1; capture old word; go to MERGE.
  - Store with be=4'h0: no memory strobe; go to RESP.
- MERGE:
  - mem_write=1.
  - mem_write_data byte i = be[i] ? wdata byte i : old byte i.
  - Go to RESP.
- RESP:
  - Owner's pN_done=1 and pN_rdata=rdata_q (0 after stores).
  - Go to IDLE.
- mem_read and mem_write are decoded from the state register only; they are never both 1.
- mem_addr is driven from the latched address in ACCESS/MERGE and is 0 elsewhere.
- Non-owner gnt, done and rdata outputs stay 0.
- A request that arrives while the block is busy waits; requesters must hold it until granted.

## Timing
- Grant cycle T (in IDLE). Load or full store: done at T+2. Partial store: done at T+3. be=0 store: done at T+2.
- Next grant no earlier than the cycle after RESP, giving one access per 3 cycles (4 for partial stores).
- Reset values:
  - State = IDLE.
  - All gnt/done = 0, all rdata = 0.
  - mem_read = 0, mem_write = 0, mem_addr = 0, mem_write_data = 0.
  - last_owner = 1, so port 0 wins the first tie.
- Reset asserted mid-operation:
  - Outputs drop to reset values immediately (asynchronous).
  - A MERGE write in progress is suppressed; no done is issued; the transaction is lost.
- A requester may drop req the cycle after gnt. Holding req after gnt issues a new request.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. When both request in IDLE, grant the port that is not last_owner. last_owner updates on every grant.
- Not defined: fixed priority. Port 0 always wins ties. last_owner is still maintained but unused.

## Test plan
- Port 0 loads 0x0000_0008 with word 2 = 0xDEADBEEF: p0_gnt at T; mem_read at T+1 with mem_addr=0x8; p0_done at T+2 with p0_rdata=0xDEADBEEF.
- Port 1 stores 0x1234_5678 to 0x10 with be=4'hF: mem_write at T+1 with data 0x12345678; p1_done at T+2; a later load of 0x10 returns 0x12345678.
- Word at 0x4 = 0xAABBCCDD, port 0 stores 0x0000_EE00 with be=4'h2: mem_read at T+1, mem_write at T+2 with data 0xAABBEEDD, p0_done at T+3.
- Both ports request continuously with RR enabled: grants alternate 0,1,0,1 starting with port 0. Without the macro, port 1 is never granted while p0_req stays high.
- rst_n pulled low during MERGE: mem_write falls without waiting for a clock edge; the memory word is unchanged; no done pulse; after release the block is in IDLE and the first grant goes to port 0.
- Store with be=4'h0: no mem_read or mem_write in any cycle; done at T+2.
